round_sequencer: RTL and testbench

Central controller for the count-guess game. It sequences the countdown counter, random generator, beeper and 7-seg display through three guessing rounds of increasing width (5/6/7 bits). It sits between the switch/button inputs and the peripheral blocks, replacing ad-hoc per-state enable logic with one registered FSM. All peripheral enables and selects are registered outputs.

---
 rtl/game_pkg.sv | 24 ++
 rtl/round_sequencer_if.sv | 20 ++
 rtl/btn_pulse.sv | 37 +++
 rtl/round_sequencer.sv | 115 +++++++++++
 tb/tb_round_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, beep modes, output bundle and round mask for the guess game
package game_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_GREET, S_ARM, S_PLAY, S_JUDGE, S_PASS_BEEP, S_FAIL_BEEP, S_VICTORY
   } state_t;
   localparam logic [1:0] BEEP_NONE = 2'd0;
   localparam logic [1:0] BEEP_PASS = 2'd1;
   localparam logic [1:0] BEEP_FAIL = 2'd2;
   typedef struct packed {
      logic        rand_st;
      logic        cst;
      logic        dzst;
      logic [2:0]  dz_num;
      logic        bst;
      logic [1:0]  beep_mode;
      logic        dst;
      logic [1:0]  disp_num;
      logic [15:0] led;
   } outs_t;
   // level 1/2/3 keeps the low 5/6/7 bits
   function automatic logic [6:0] lvl_mask(input logic [1:0] lvl);
      return 7'h7F >> (2'd3 - lvl);
   endfunction
endpackage

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: player/peripheral signals of the guess game sequencer
//   master drives enable, buttons, guess, rand_num, cnt_over, beep_over
//   slave (the sequencer) drives peripheral enables/selects, led, level, fail_cnt
interface round_sequencer_if;
   logic        enable, start_btn, restart_btn, cnt_over, beep_over;
   logic [6:0]  guess, rand_num;
   logic        rand_st, cst, dzst, bst, dst;
   logic [2:0]  dz_num;
   logic [1:0]  beep_mode, disp_num, level;
   logic [15:0] led;
   logic [3:0]  fail_cnt;
   modport master (
      output enable, start_btn, restart_btn, cnt_over, beep_over, guess, rand_num,
      input  rand_st, cst, dzst, dz_num, bst, beep_mode, dst, disp_num, led, level, fail_cnt
   );
   modport slave (
      input  enable, start_btn, restart_btn, cnt_over, beep_over, guess, rand_num,
      output rand_st, cst, dzst, dz_num, bst, beep_mode, dst, disp_num, led, level, fail_cnt
   );
endinterface

// File: rtl/btn_pulse.sv
// btn_pulse: 2-flop sync + debounce, one-cycle pulse on an accepted rising edge
//   clk, rst_n (async, active-low), btn (raw), pulse (registered)
module btn_pulse #(
   parameter int DEB_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d, pulse_q, pulse_d, flip;
   always_comb begin
      sync_d   = {sync_q[0], btn};
      // accept the new level once it has differed for DEB_CYCLES consecutive cycles
      flip     = (sync_q[1] != stable_q) && (cnt_q == CW'(DEB_CYCLES - 1));
      cnt_d    = (sync_q[1] == stable_q || flip) ? '0 : cnt_q + 1'b1;
      stable_d = flip ? sync_q[1] : stable_q;
      pulse_d  = flip & sync_q[1];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
      end
   end
   assign pulse = pulse_q;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: registered FSM running three guessing rounds of the count-guess game
//   clk, rst_n (async, active-low)
//   bus.slave: switch/button/peripheral inputs in; peripheral enables/selects, led, level, fail_cnt out
module round_sequencer import game_pkg::*; #(
   parameter int DEB_CYCLES   = 20000,
   parameter int BEEP_TIMEOUT = 2000000,
   parameter int MAX_LEVEL    = 3,
   parameter int FAIL_MAX     = 15
) (
   input logic              clk,
   input logic              rst_n,
   round_sequencer_if.slave bus
);
   localparam int WDW = $clog2(BEEP_TIMEOUT + 1);
   state_t         state_q, state_d;
   logic [1:0]     en_sync_q, en_sync_d, level_q, level_d;
   logic [3:0]     fail_q, fail_d;
   logic [6:0]     target_q, target_d, mask;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic           over_seen_q, over_seen_d, start_p, restart_p, beep_done;
   outs_t          out_q, out_d;
   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_start   (.clk, .rst_n, .btn(bus.start_btn),   .pulse(start_p));
   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_restart (.clk, .rst_n, .btn(bus.restart_btn), .pulse(restart_p));
   assign mask      = lvl_mask(level_q);
   assign beep_done = wdog_q == WDW'(BEEP_TIMEOUT - 1);
   always_comb begin
      en_sync_d   = {en_sync_q[0], bus.enable};
      state_d     = state_q;
      level_d     = level_q;
      fail_d      = fail_q;
      target_d    = target_q;
      over_seen_d = over_seen_q;
      // beep states are only entered from JUDGE, so anything else clears the watchdog
      wdog_d      = (state_q == S_PASS_BEEP || state_q == S_FAIL_BEEP) ? wdog_q + 1'b1 : '0;
      if (!en_sync_q[1])
         state_d = S_IDLE;
      else if (restart_p) begin
         state_d = S_ARM;
         level_d = 2'd1;
         fail_d  = '0;
      end else
         case (state_q)
            S_IDLE: state_d = S_GREET;
            S_ARM: begin
               target_d    = bus.rand_num & mask;
               over_seen_d = 1'b0;
               state_d     = S_PLAY;
            end
            S_PLAY: begin
               over_seen_d = over_seen_q | bus.cnt_over;
               if (start_p && over_seen_q) state_d = S_JUDGE;
            end
            S_JUDGE:
               if (((bus.guess ^ target_q) & mask) == '0)
                  state_d = S_PASS_BEEP;
               else begin
                  state_d = S_FAIL_BEEP;
                  fail_d  = (fail_q == FAIL_MAX[3:0]) ? fail_q : fail_q + 4'd1;
               end
            S_PASS_BEEP:
               if (bus.beep_over || beep_done) begin
                  if (level_q == MAX_LEVEL[1:0])
                     state_d = S_VICTORY;
                  else begin
                     level_d = level_q + 2'd1;
                     state_d = S_ARM;
                  end
               end
            S_FAIL_BEEP: if (bus.beep_over || beep_done) state_d = S_ARM;
            default: ;
         endcase
      // outputs follow the current state, so they land one cycle after state entry
      out_d.rand_st   = state_q inside {S_GREET, S_PASS_BEEP, S_FAIL_BEEP};
      out_d.cst       = state_q == S_PLAY;
      out_d.dzst      = state_q inside {S_GREET, S_PLAY, S_VICTORY};
      out_d.dz_num    = (state_q inside {S_GREET, S_PLAY}) ? 3'd3 : 3'd0;
      out_d.bst       = state_q inside {S_PASS_BEEP, S_FAIL_BEEP};
      out_d.beep_mode = state_q == S_PASS_BEEP ? BEEP_PASS : state_q == S_FAIL_BEEP ? BEEP_FAIL : BEEP_NONE;
      out_d.dst       = state_q inside {S_PLAY, S_VICTORY};
      out_d.disp_num  = state_q == S_PLAY ? level_q : state_q == S_VICTORY ? MAX_LEVEL[1:0] : 2'd0;
      out_d.led       = state_q == S_VICTORY ? 16'hFFFF : state_q == S_PLAY ? {9'd0, target_q} : 16'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         en_sync_q   <= '0;
         level_q     <= 2'd1;
         fail_q      <= '0;
         target_q    <= '0;
         over_seen_q <= 1'b0;
         wdog_q      <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         en_sync_q   <= en_sync_d;
         level_q     <= level_d;
         fail_q      <= fail_d;
         target_q    <= target_d;
         over_seen_q <= over_seen_d;
         wdog_q      <= wdog_d;
         out_q       <= out_d;
      end
   end
   assign bus.rand_st   = out_q.rand_st;
   assign bus.cst       = out_q.cst;
   assign bus.dzst      = out_q.dzst;
   assign bus.dz_num    = out_q.dz_num;
   assign bus.bst       = out_q.bst;
   assign bus.beep_mode = out_q.beep_mode;
   assign bus.dst       = out_q.dst;
   assign bus.disp_num  = out_q.disp_num;
   assign bus.led       = out_q.led;
   assign bus.level     = level_q;
   assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios checked against a phase-level model every cycle
module tb_round_sequencer;
   localparam int DEB = 4;
   localparam int BT  = 50;
   localparam int P_IDLE = 0, P_GREET = 1, P_ARM = 2, P_PLAY = 3, P_JUDGE = 4, P_PASS = 5, P_FAIL = 6, P_WIN = 7;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   round_sequencer_if bus();
   round_sequencer #(.DEB_CYCLES(DEB), .BEEP_TIMEOUT(BT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int          ph = P_IDLE, m_lvl = 1, m_fail = 0, m_beep = 0, m_msk = 0;
   logic [6:0]  m_tgt = '0;
   bit          m_seen = 0, sp = 0, rp = 0;
   logic [15:0] st_h = '0, rs_h = '0;
   logic [2:0]  en_h = '0;
   logic [27:0] m_out = '0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   // a press is seen once the raw button has been high for DEB samples, delayed by the 2-flop sync
   function automatic bit pulse_of(input logic [15:0] h);
      bit ok = !h[DEB+3];
      for (int i = 3; i <= DEB + 2; i++) ok &= h[i];
      return ok;
   endfunction
   function automatic logic [27:0] outs_for(input int p, input int lvl, input logic [6:0] tgt);
      logic rs = 0, cs = 0, dz = 0, bs = 0, ds = 0;
      logic [2:0] dn = 0;
      logic [1:0] bm = 0, dp = 0;
      logic [15:0] ld = 0;
      case (p)
         P_GREET: begin rs = 1; dz = 1; dn = 3; end
         P_PLAY:  begin cs = 1; dz = 1; dn = 3; ds = 1; dp = 2'(lvl); ld = {9'd0, tgt}; end
         P_PASS:  begin bs = 1; bm = 1; rs = 1; end
         P_FAIL:  begin bs = 1; bm = 2; rs = 1; end
         P_WIN:   begin ld = 16'hFFFF; dz = 1; ds = 1; dp = 3; end
         default: ;
      endcase
      return {rs, cs, dz, dn, bs, bm, ds, dp, ld};
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = P_IDLE; m_lvl = 1; m_fail = 0; m_tgt = '0; m_seen = 0; m_beep = 0;
         st_h = '0; rs_h = '0; en_h = '0; m_out = '0;
      end else begin
         m_out = outs_for(ph, m_lvl, m_tgt);
         st_h = {st_h[14:0], bus.start_btn};
         rs_h = {rs_h[14:0], bus.restart_btn};
         en_h = {en_h[1:0], bus.enable};
         sp = pulse_of(st_h);
         rp = pulse_of(rs_h);
         m_msk = (1 << (4 + m_lvl)) - 1;
         if (!en_h[2]) ph = P_IDLE;
         else if (rp) begin ph = P_ARM; m_lvl = 1; m_fail = 0; end
         else case (ph)
            P_IDLE: ph = P_GREET;
            P_ARM: begin m_tgt = 7'(int'(bus.rand_num) & m_msk); m_seen = 0; ph = P_PLAY; end
            P_PLAY: begin
               if (sp && m_seen) ph = P_JUDGE;
               if (bus.cnt_over) m_seen = 1;
            end
            P_JUDGE: begin
               m_beep = 0;
               if ((int'(bus.guess) & m_msk) == int'(m_tgt)) ph = P_PASS;
               else begin ph = P_FAIL; m_fail = (m_fail == 15) ? 15 : m_fail + 1; end
            end
            P_PASS, P_FAIL: begin
               m_beep++;
               if (bus.beep_over || m_beep == BT) begin
                  if (ph == P_FAIL) ph = P_ARM;
                  else if (m_lvl == 3) ph = P_WIN;
                  else begin m_lvl++; ph = P_ARM; end
               end
            end
            default: ;
         endcase
      end
   end
   always @(negedge clk) begin
      chk("outputs", {4'd0, bus.rand_st, bus.cst, bus.dzst, bus.dz_num, bus.bst, bus.beep_mode,
                      bus.dst, bus.disp_num, bus.led}, {4'd0, m_out});
      chk("level", {30'd0, bus.level}, m_lvl);
      chk("fail_cnt", {28'd0, bus.fail_cnt}, m_fail);
   end
   function automatic bit cond(input int sel);
      return sel == 0 ? bus.bst : sel == 1 ? bus.cst : (bus.led == 16'hFFFF);
   endfunction
   task automatic wait_for(input string nm, input int sel);
      int n = 0;
      while (!cond(sel) && n < 300) begin @(negedge clk); n++; end
      n_cmp++;
      if (!cond(sel)) begin
         n_err++;
         $display("FAIL wait_%s: condition not reached after %0d cycles, required within 300", nm, n);
      end
   endtask
   task automatic press(input int sel);
      bus.start_btn   = (sel != 1);
      bus.restart_btn = (sel != 0);
      repeat (8) @(negedge clk);
      bus.start_btn   = 1'b0;
      bus.restart_btn = 1'b0;
   endtask
   task automatic pulse_cnt();
      bus.cnt_over = 1'b1;
      @(negedge clk);
      bus.cnt_over = 1'b0;
   endtask
   task automatic beep();
      bus.beep_over = 1'b1;
      @(negedge clk);
      bus.beep_over = 1'b0;
   endtask
   initial begin
      int n;
      bus.enable = 0; bus.start_btn = 0; bus.restart_btn = 0;
      bus.guess = '0; bus.rand_num = '0; bus.cnt_over = 0; bus.beep_over = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_led", bus.led, 0);
      chk("rst_rand_st", bus.rand_st, 0);
      chk("rst_level", bus.level, 1);
      chk("rst_fail", bus.fail_cnt, 0);
      rst_n = 1'b1;
      bus.enable = 1'b1;
      repeat (6) @(negedge clk);
      chk("greet_rand_st", bus.rand_st, 1);
      chk("greet_dzst", bus.dzst, 1);
      chk("greet_dz_num", bus.dz_num, 3);
      chk("greet_cst", bus.cst, 0);
      chk("greet_bst", bus.bst, 0);
      chk("greet_dst", bus.dst, 0);
      // round 1: 5A masked to 5 bits is 1A
      bus.rand_num = 7'h5A;
      press(1);
      wait_for("play1", 1);
      chk("l1_led", bus.led, 16'h001A);
      chk("l1_disp", bus.disp_num, 1);
      chk("l1_model_tgt", m_tgt, 7'h1A);
      pulse_cnt();
      bus.guess = 7'h1A;
      press(0);
      wait_for("pass1", 0);
      chk("l1_beep_mode", bus.beep_mode, 1);
      chk("l1_rand_st", bus.rand_st, 1);
      bus.rand_num = 7'h6C;
      beep();
      repeat (2) @(negedge clk);
      chk("l2_level", bus.level, 2);
      // round 2: an early start is dropped, then a wrong guess times out
      wait_for("play2", 1);
      chk("l2_led", bus.led, 16'h002C);
      bus.guess = 7'h2D;
      press(0);
      repeat (10) @(negedge clk);
      chk("early_start_cst", bus.cst, 1);
      chk("early_start_bst", bus.bst, 0);
      pulse_cnt();
      press(0);
      wait_for("fail2", 0);
      chk("l2_beep_mode", bus.beep_mode, 2);
      chk("l2_fail_cnt", bus.fail_cnt, 1);
      n = 0;
      while (bus.bst && n < 200) begin n++; @(negedge clk); end
      chk("timeout_cycles", n, BT);
      chk("l2_level_kept", bus.level, 2);
      // retry: bit 6 of the guess lies outside the 6-bit round and is ignored
      wait_for("play2b", 1);
      pulse_cnt();
      bus.guess = 7'h6C;
      press(0);
      wait_for("pass2", 0);
      chk("l2_pass_mode", bus.beep_mode, 1);
      bus.rand_num = 7'h33;
      beep();
      // round 3: start pulse lands in the same cycle as cnt_over and must be ignored
      wait_for("play3", 1);
      chk("l3_led", bus.led, 16'h0033);
      chk("l3_disp", bus.disp_num, 3);
      bus.guess = 7'h33;
      bus.start_btn = 1'b1;
      repeat (6) @(negedge clk);
      bus.cnt_over = 1'b1;
      @(negedge clk);
      bus.cnt_over = 1'b0;
      @(negedge clk);
      bus.start_btn = 1'b0;
      repeat (4) @(negedge clk);
      chk("coinc_cst", bus.cst, 1);
      chk("coinc_bst", bus.bst, 0);
      repeat (10) @(negedge clk);
      press(0);
      wait_for("pass3", 0);
      beep();
      wait_for("victory", 2);
      chk("win_disp", bus.disp_num, 3);
      chk("win_dzst", bus.dzst, 1);
      chk("win_dz_num", bus.dz_num, 0);
      chk("win_dst", bus.dst, 1);
      chk("win_bst", bus.bst, 0);
      // restart and start together: restart wins
      press(2);
      repeat (4) @(negedge clk);
      chk("restart_level", bus.level, 1);
      chk("restart_fail", bus.fail_cnt, 0);
      wait_for("play4", 1);
      chk("restart_led", bus.led, 16'h0013);
      // enable drop in the middle of a pass beep
      repeat (10) @(negedge clk);
      pulse_cnt();
      bus.guess = 7'h13;
      press(0);
      wait_for("pass4", 0);
      bus.enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("drop_bst", bus.bst, 0);
      chk("drop_rand_st", bus.rand_st, 0);
      chk("drop_beep_mode", bus.beep_mode, 0);
      chk("drop_level", bus.level, 1);
      // asynchronous reset mid-PLAY takes effect between clock edges
      bus.enable = 1'b1;
      repeat (8) @(negedge clk);
      press(1);
      wait_for("play5", 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_cst", bus.cst, 0);
      chk("async_led", bus.led, 0);
      chk("async_dzst", bus.dzst, 0);
      chk("async_level", bus.level, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
